// File: rtl/eth_tx_arb_pkg.sv
// Shared types and abort-beat constants for the 10G MAC transmit arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam logic [7:0]  ABORT_TKEEP = 8'h01;
    localparam logic [63:0] ABORT_TDATA = 64'h0;

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Rotate-priority encoder: first eligible requester after i_last_grant, wrapping.
module eth_tx_arb_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    input  logic [NUM_SRC-1:0] i_mask,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_idx
);

    logic [NUM_SRC-1:0] w_elig;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_cand;

    // Walk candidates from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        w_elig = i_req & ~i_mask;
        w_idx  = '0;
        w_cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_cand = ID_W'((int'(i_last_grant) + k) % NUM_SRC);
            w_idx  = w_elig[w_cand] ? w_cand : w_idx;
        end
    end

    assign o_valid = |w_elig;
    assign o_idx   = w_idx;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10G MAC AXI-Stream TX port.
// Optional stalled-source watchdog: define ETH_TX_ARB_WATCHDOG_EN.
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int TIMEOUT    = 255,
    parameter int ID_W       = $clog2(NUM_SRC)
) (
    input  logic                         clk156,
    input  logic                         sys_rst156,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]           s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
);

    if (NUM_SRC < 2 || NUM_SRC > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("eth_tx_arbiter: unsupported parameter set");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_grant;
    logic [ID_W-1:0]         r_last_grant;
    logic                    r_m_tvalid;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [KEEP_WIDTH-1:0]   r_m_tkeep;
    logic                    r_m_tlast;

    logic                    w_pick_valid;
    logic [ID_W-1:0]         w_pick_idx;
    logic [NUM_SRC-1:0]      w_drain_mask;
    logic [NUM_SRC-1:0]      w_ready;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [KEEP_WIDTH-1:0]   w_sel_keep;
    logic                    w_out_free;
    logic                    w_acc;
    logic                    w_frame_done;
    logic                    w_release;
    logic                    w_load_grant;

    eth_tx_arb_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req        (s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .i_mask       (w_drain_mask),
        .o_valid      (w_pick_valid),
        .o_idx        (w_pick_idx)
    );

    // Mux the granted source's beat onto the selection bus.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel_valid = (r_grant == ID_W'(i)) ? s_axis_tvalid[i] : w_sel_valid;
            w_sel_last  = (r_grant == ID_W'(i)) ? s_axis_tlast[i]  : w_sel_last;
            w_sel_data  = (r_grant == ID_W'(i)) ? s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] : w_sel_data;
            w_sel_keep  = (r_grant == ID_W'(i)) ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] : w_sel_keep;
        end
    end

    assign w_out_free   = ~r_m_tvalid | m_axis_tready;
    assign w_acc        = (r_state == ST_PASS) & w_sel_valid & w_out_free;
    assign w_frame_done = w_acc & w_sel_last;

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_SRC-1:0] r_draining;
    logic               r_m_tuser;
    logic               w_timeout;
    logic               w_abort_done;
    logic [NUM_SRC-1:0] w_drain_clr;
    logic [NUM_SRC-1:0] w_drain_set;

    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT));
    assign w_abort_done = (r_state == ST_ABORT) & w_out_free;
    assign w_release    = w_frame_done | w_abort_done;
    assign w_drain_mask = r_draining;
    assign m_axis_tuser = r_m_tuser;

    // Stall counter: saturates at TIMEOUT, only counts when the output could take a beat.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            r_cnt <= '0;
        end else if (w_load_grant || w_acc) begin
            r_cnt <= '0;
        end else if ((r_state == ST_PASS) && !w_sel_valid && w_out_free && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Draining sources stay readied; their tlast beat ends the drain.
    always_comb begin
        w_drain_clr          = r_draining & s_axis_tvalid & s_axis_tlast;
        w_drain_set          = '0;
        w_drain_set[r_grant] = w_abort_done;
    end

    // Draining flag register.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            r_draining <= '0;
        end else begin
            r_draining <= (r_draining & ~w_drain_clr) | w_drain_set;
        end
    end
`else
    assign w_release    = w_frame_done;
    assign w_drain_mask = '0;
    assign m_axis_tuser = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = ST_PASS;
                    w_load_grant = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (w_frame_done) begin
                    w_state_nxt = ST_IDLE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
                end else if (w_timeout) begin
                    w_state_nxt = ST_ABORT;
`endif
                end else begin
                    w_state_nxt = ST_PASS;
                end
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            ST_ABORT: begin
                if (w_out_free) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ABORT;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_SRC - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_load_grant) begin
                r_grant <= w_pick_idx;
            end
            if (w_release) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Output beat register; holds under backpressure.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            r_m_tuser  <= 1'b0;
`endif
        end else if (w_acc) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_data;
            r_m_tkeep  <= w_sel_keep;
            r_m_tlast  <= w_sel_last;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            r_m_tuser  <= 1'b0;
        end else if (w_abort_done) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= DATA_WIDTH'(ABORT_TDATA);
            r_m_tkeep  <= KEEP_WIDTH'(ABORT_TKEEP);
            r_m_tlast  <= 1'b1;
            r_m_tuser  <= 1'b1;
`endif
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Only the granted source (or a draining one) is ever readied.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ready[i] = w_drain_mask[i] |
                         ((r_state == ST_PASS) & (r_grant == ID_W'(i)) & w_out_free);
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign grant_id      = r_grant;
    assign busy          = (r_state != ST_IDLE);

endmodule
